// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronises and oversamples the RX pin, deframes characters
// and buffers them in a small FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV = 87,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_i_rx,
    output logic                     io_o_valid,
    output logic [7:0]               io_o_data,
    input  logic                     io_i_ready,
    output logic                     io_o_frame_err,
    output logic                     io_o_overrun,
    input  logic                     io_i_clear,
    output logic [$clog2(DEPTH):0]   io_o_count
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [15:0] HalfBit = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FullBit = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic       sync1_q;
    logic       rx_s;
    logic       rx_prev_q;
    logic [1:0] sync_ok_q;
    logic       armed_q;
    logic       fall;

    // Edges are only accepted once a genuine high has passed the synchroniser since
    // reset, so a character interrupted by reset is not mistaken for a new start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
            sync_ok_q <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            sync1_q   <= io_i_rx;
            rx_s      <= sync1_q;
            rx_prev_q <= rx_s;
            sync_ok_q <= {sync_ok_q[0], 1'b1};
            armed_q   <= armed_q | (sync_ok_q[1] & rx_s);
        end
    end

    assign fall = armed_q & rx_prev_q & ~rx_s;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        push_req;
    logic        frame_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_evt = 1'b0;
        if (state_q != StIdle && cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = HalfBit;
                end
            end
            StStart: begin
                if (cnt_q == 16'd0) begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = FullBit;
                        bit_d   = 3'd0;
                    end
                end
            end
            StData: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FullBit;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == 16'd0) begin
                    state_d   = StIdle;
                    push_req  = rx_s;
                    frame_evt = ~rx_s;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        full;
    logic        pop;
    logic        push;
    logic        overrun_evt;

    // Pointers carry one extra bit so full and empty differ only in the MSB.
    assign io_o_count  = wr_q - rd_q;
    assign io_o_valid  = (wr_q != rd_q);
    assign full        = (io_o_count == (AW + 1)'(DEPTH));
    assign pop         = io_o_valid & io_i_ready;
    assign push        = push_req & (~full | pop);
    assign overrun_evt = push_req & full & ~pop;
    assign io_o_data   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= shift_q;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    logic frame_err_q, overrun_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_evt | (frame_err_q & ~io_i_clear);
            overrun_q   <= overrun_evt | (overrun_q & ~io_i_clear);
        end
    end

    assign io_o_frame_err = frame_err_q;
    assign io_o_overrun   = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive stage of the system's UART: takes the raw UART RX pin, synchronises and oversamples it, deframes 8N1 characters and buffers them in a small FIFO. The core's UART peripheral drains the FIFO through a valid/ready handshake. Framing errors and overruns are reported through sticky flags. The block sits between the top-level RX pad and the UART register interface inside the system.

## Interface
- CLK_DIV, 87, clock cycles per bit period (87 ≈ 10 MHz / 115200); legal range 4..65535
- DEPTH, 4, FIFO entries; power of two, 2..16
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- io_i_rx  in  1  raw UART RX line, idle high, asynchronous to clock
- io_o_valid  out  1  FIFO non-empty; io_o_data holds the oldest byte
- io_o_data  out  8  FIFO head byte
- io_i_ready  in  1  consumer accepts the head byte when io_o_valid & io_i_ready
- io_o_frame_err  out  1  sticky: stop bit sampled low
- io_o_overrun  out  1  sticky: a byte completed while the FIFO was full
- io_i_clear  in  1  clears both sticky flags
- io_o_count  out  log2(DEPTH)+1  number of bytes held in the FIFO

## Operation
- Synchroniser: two flops on io_i_rx, both reset to 1. All logic uses the second-stage output (rx_s). An edge detector compares rx_s against a third flop, which also resets to 1.
- Bit counter: 16-bit down-counter. Bit index: 3 bits, counting 0..7.
- FSM states: IDLE, START, DATA, STOP. Reset state is IDLE.
  - IDLE: when rx_s falls, go to START and load counter = CLK_DIV/2 − 1 (integer division).
  - START: when counter = 0, sample rx_s. If 1, treat as a glitch and return to IDLE. If 0, go to DATA with counter = CLK_DIV − 1 and bit index = 0.
  - DATA: when counter = 0, shift rx_s into the shift register LSB-first and reload counter = CLK_DIV − 1. After bit index 7, go to STOP.
  - STOP: when counter = 0, sample rx_s.
    - If 1: push the byte.
    - If 0: discard the byte and set frame_err.
    - In both cases go to IDLE in the same cycle. A new start edge is accepted from the next cycle.
- FIFO: circular buffer of DEPTH entries. Read and write pointers are log2(DEPTH)+1 bits wide, so full and empty are distinguished by the extra MSB. Pointers wrap modulo 2·DEPTH.
  - Pop: io_o_valid & io_i_ready.
  - Push: a good stop bit with (not full, or a pop in the same cycle).
  - Push while full with no pop: the new byte is dropped, overrun is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both take effect and io_o_count is unchanged.
- Sticky flags: set by their event and cleared by io_i_clear. If set and clear happen in the same cycle, set wins.
- io_o_data is combinational from the head entry. Its value is don't-care while io_o_valid = 0.

## Timing
- Reset values:
  - io_o_valid = 0, io_o_count = 0
  - io_o_frame_err = 0, io_o_overrun = 0
  - io_o_data = 0, because storage is reset
  - FSM = IDLE, synchroniser flops = 1
- Pin-to-detect delay: 2 cycles of synchronisation plus 1 cycle of edge detection.
- Data bit n is sampled CLK_DIV/2 + (n+1)·CLK_DIV cycles after the falling edge is detected, which is mid-bit.
- The stop bit is sampled CLK_DIV/2 + 9·CLK_DIV cycles after detection. io_o_valid rises in the cycle after that sample, when the FIFO was empty.
- Back-to-back characters with zero idle time are received without loss.
- Pop takes effect at the clock edge. The next entry, or valid = 0, appears in the following cycle.
- Reset asserted mid-character:
  - Returns the FSM to IDLE, empties the FIFO and clears the flags immediately.
  - The remainder of the character in flight is ignored until rx_s has been seen high and then falls again.
- io_i_rx held low for the whole frame (break): produces frame_err with no push. The FSM then stays in IDLE until the line returns high and falls again.

## Test plan
- CLK_DIV=16, DEPTH=4. Send 0xA5 as 8N1 with ready=1 → exactly one cycle with valid=1 and data=0xA5; count returns to 0; both flags stay 0.
- Send 0x00, 0xFF, 0x3C back-to-back with ready=0 → count=3. Then raise ready → data is 0x00, 0xFF, 0x3C on consecutive cycles, then valid=0.
- Send 5 bytes 0x01..0x05 with ready=0 → count=4, overrun=1, head=0x01, 0x05 is lost. Pulse clear → overrun=0.
- Send 0x55 with the stop bit driven low → no push, frame_err=1, count unchanged. Then send 0x66 correctly → 0x66 received and frame_err still 1.
- Drive a 4-cycle low glitch on rx (shorter than CLK_DIV/2) → FSM returns to IDLE, no push, no flags set.
- Assert reset in the middle of bit 4 of 0xC3 while the FIFO holds 2 bytes → count=0, valid=0 and flags=0 immediately. The next correctly framed 0x7E is received intact.
